// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared definitions for the lease arbiter: FSM state encoding
//                and default sizing.
//  Contents    : lease_state_t  - IDLE / GRANT / REVOKE
//                N_DEFAULT      - default number of requesters
//                LEASE_DEFAULT  - default lease length in grant cycles
//                OWNER_W        - owner index width for the default N
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int N_DEFAULT     = 8;
    localparam int LEASE_DEFAULT = 16;
    localparam int OWNER_W       = $clog2(N_DEFAULT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        REVOKE = 2'd2
    } lease_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotate-priority encoder. Returns the first set
//                request found scanning ptr, ptr+1, ... wrapping at N-1.
//  Ports       : req   [N-1:0]  in   request vector
//                ptr   [W-1:0]  in   highest-priority index (0..N-1)
//                valid          out  at least one request is set
//                idx   [W-1:0]  out  selected index (0 when !valid)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int W = $clog2(N);
    localparam logic [W:0] N_EXT = N[W:0];

    // One extra bit so ptr + offset (at most 2N-2) never overflows before
    // the wrap subtraction.
    logic [W:0] w_pos;

    always_comb begin
        valid = |req;
        idx   = '0;
        w_pos = '0;
        // Scan from the farthest offset down to zero so the closest set
        // request (smallest offset from ptr) is the last one written.
        for (int k = N - 1; k >= 0; k--) begin
            w_pos = {1'b0, ptr} + k[W:0];
            if (w_pos >= N_EXT) begin
                w_pos = w_pos - N_EXT;
            end
            if (req[w_pos[W-1:0]]) begin
                idx = w_pos[W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lease_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lease_arbiter
//  Description : Round-robin arbiter with a hold-time lease. A client keeps
//                req high while it owns the resource and drops it to release.
//                After LEASE grant cycles revoke asks the owner to let go;
//                the grant itself is never withdrawn by the arbiter.
//  Ports       : clk              in   clock, rising edge
//                rst_n            in   asynchronous active-low reset
//                req    [N-1:0]   in   per-client request
//                enable           in   1 = new grants allowed, 0 = drain
//                ack    [N-1:0]   out  one-hot grant, zero when no owner
//                revoke           out  lease expired, owner should release
//                busy             out  an owner exists
//                owner  [W-1:0]   out  owner index, 0 when not busy
//  Revision    : 1.0 - initial release
// ============================================================================
module lease_arbiter
    import arb_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int LEASE = LEASE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 enable,
    output logic [N-1:0]         ack,
    output logic                 revoke,
    output logic                 busy,
    output logic [$clog2(N)-1:0] owner
);

    localparam int OW = $clog2(N);
    localparam logic [OW-1:0] LAST_IDX   = OW'(N - 1);
    localparam logic [7:0]    LEASE_LAST = 8'(LEASE - 1);

    lease_state_t   r_state;
    lease_state_t   w_state_nxt;
    logic [OW-1:0]  r_ptr;
    logic [OW-1:0]  w_ptr_nxt;
    logic [7:0]     r_cnt;
    logic [7:0]     w_cnt_nxt;
    logic [N-1:0]   w_ack_nxt;
    logic           w_revoke_nxt;
    logic           w_busy_nxt;
    logic [OW-1:0]  w_owner_nxt;

    logic           w_pick_valid;
    logic [OW-1:0]  w_pick_idx;
    logic [OW-1:0]  w_ptr_after_owner;

    rr_pick #(
        .N (N)
    ) u_rr_pick (
        .req   (req),
        .ptr   (r_ptr),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    // Priority moves just past the releasing owner so it goes to the back.
    assign w_ptr_after_owner = (owner == LAST_IDX) ? '0 : owner + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            ack     <= '0;
            revoke  <= 1'b0;
            busy    <= 1'b0;
            owner   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            ack     <= w_ack_nxt;
            revoke  <= w_revoke_nxt;
            busy    <= w_busy_nxt;
            owner   <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ack_nxt    = ack;
        w_revoke_nxt = revoke;
        w_busy_nxt   = busy;
        w_owner_nxt  = owner;
        w_ptr_nxt    = r_ptr;
        w_cnt_nxt    = r_cnt;

        case (r_state)
            IDLE: begin
                if (enable && w_pick_valid) begin
                    w_state_nxt             = GRANT;
                    w_ack_nxt               = '0;
                    w_ack_nxt[w_pick_idx]   = 1'b1;
                    w_owner_nxt             = w_pick_idx;
                    w_busy_nxt              = 1'b1;
                    w_cnt_nxt               = '0;
                end
            end

            GRANT: begin
                // Release takes precedence over lease expiry on the same edge.
                if (!req[owner]) begin
                    w_state_nxt = IDLE;
                    w_ack_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_owner_nxt = '0;
                    w_ptr_nxt   = w_ptr_after_owner;
                end else if (r_cnt == LEASE_LAST) begin
                    w_state_nxt  = REVOKE;
                    w_revoke_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end

            REVOKE: begin
                if (!req[owner]) begin
                    w_state_nxt  = IDLE;
                    w_ack_nxt    = '0;
                    w_revoke_nxt = 1'b0;
                    w_busy_nxt   = 1'b0;
                    w_owner_nxt  = '0;
                    w_ptr_nxt    = w_ptr_after_owner;
                end
            end

            default: begin
                w_state_nxt  = IDLE;
                w_ack_nxt    = '0;
                w_revoke_nxt = 1'b0;
                w_busy_nxt   = 1'b0;
                w_owner_nxt  = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/lease_arbiter.md
# lease_arbiter

Synchronous round-robin arbiter that shares one resource among N client processes. It uses the same four-phase req/ack discipline as the tree arbiter cells: a client holds req through its locking phase and drops it to release. The block adds a hold-time lease. When the lease expires, the block asks the owner to release; it never forcibly removes the grant. It sits as a flat alternative at the root level, fed by the same client processes, and produces a one-hot grant plus owner index for the resource.

## Interface
Parameters:
- N, 8, number of requesters (2..16)
- LEASE, 16, grant cycles before revoke is raised (1..255)

Ports:
- clk  input  1  clock; all state updates on posedge
- rst_n  input  1  asynchronous, active-low reset
- req  input  N  per-client request; held high through the locking phase
- enable  input  1  1 = new grants allowed; 0 = drain (the current grant continues)
- ack  output  N  one-hot grant to the owner; all zero when no owner
- revoke  output  1  lease expired; owner is asked to drop req
- busy  output  1  an owner exists (ack != 0)
- owner  output  $clog2(N)  index of the current owner; 0 when not busy

## Operation
- States: IDLE, GRANT, REVOKE. All outputs are registered.
- Reset (async, rst_n=0): state=IDLE, ack=0, revoke=0, busy=0, owner=0, ptr=0, cnt=0.
- IDLE:
  - If enable and req != 0, pick the first set req[i] scanning i = ptr, ptr+1, … mod N.
  - Go to GRANT with ack[i]=1, owner=i, busy=1, cnt=0.
  - Otherwise remain in IDLE.
- GRANT:
  - If !req[owner]: go to IDLE. Clear ack/busy/owner. ptr = (owner+1) mod N.
  - Else if cnt == LEASE-1: go to REVOKE with revoke=1; ack stays high.
  - Else cnt++.
- REVOKE:
  - Hold ack and revoke; cnt is frozen.
  - If !req[owner]: go to IDLE. Clear ack/revoke/busy/owner. ptr = (owner+1) mod N.
- Only req[owner] is examined in GRANT/REVOKE; requests from other clients are ignored until the block returns to IDLE.
- Mutual exclusion: at most one ack bit is set at any time. Every release is followed by at least one cycle with ack=0, because the IDLE cycle sits between owners.
- Fairness: a requester holding req continuously is granted within N-1 other grants, provided enable stays high.
- enable only affects the IDLE decision. Dropping enable during GRANT does not shorten the lease.
- Width rules:
  - cnt is 8 bits and never exceeds LEASE-1.
  - ptr wraps from N-1 to 0.
  - owner is zero-extended index.

## Timing
- Grant latency: req[i] high at posedge t, with block in IDLE and i selected, gives ack[i]=1 from t (visible in cycle t+1).
- Release latency: req[owner] low sampled at posedge t gives ack=0 from t. The earliest next grant is posedge t+1.
- Back-to-back: a release followed by a new owner means ack is all-zero for exactly one cycle when another req is pending.
- Revoke: granted at posedge g, held continuously, gives revoke=1 from posedge g+LEASE.
- Simultaneous requests in IDLE are resolved by ptr; the lowest index wins only when ptr=0.
- req[i] pulse shorter than one cycle and not present at a posedge: ignored.
- Reset asserted mid-grant: all outputs clear immediately (asynchronously). After rst_n deasserts, the first evaluation happens at the next posedge, with ptr=0.

## Structure
- Package arb_pkg holds:
  - state enum lease_state_t {IDLE, GRANT, REVOKE}
  - the default N and LEASE localparams
  - OWNER_W = $clog2(N)
- Sub-module rr_pick: combinational rotate-priority encoder with inputs req[N] and ptr, and outputs valid and idx. It is instantiated once; the FSM, counter and pointer stay in lease_arbiter.

## Test plan
- Reset, then req=8'b0000_0100 at posedge 1: ack=8'b0000_0100, owner=2, busy=1 after posedge 1. Drop req at posedge 5: ack=0 after posedge 5; ptr=3.
- req=8'hFF held, ptr=0, each owner releases 2 cycles after grant: grant order is 0,1,…,7,0. Exactly one idle cycle between grants. ack is never multi-hot.
- LEASE=4, req[5] held for 10 cycles after grant at posedge g: revoke rises after posedge g+4. ack[5] stays high until req[5] drops; then revoke=0 and ack=0 on the same edge.
- enable=0 with req=8'h81 pending: no grant. Set enable=1: ack[0] on the next posedge. Clear enable mid-grant: the lease continues; no new grant until enable returns.
- rst_n pulled low in REVOKE with owner=3: ack, revoke, busy and owner are 0 asynchronously. After release, req=8'h08 gives ack[3] after the first posedge.
- Random req/release traffic for 10k cycles against a scoreboard: check one-hot ack, starvation bound N-1, and revoke only after LEASE cycles of continuous ownership.
